// File: rtl/conv_pkg.sv
// conv_pkg: FSM encoding, power-on kernel and 3x3 tap-offset table shared by the conv/pool engine
package conv_pkg;
  typedef enum logic [2:0] {IDLE, CONV_RD, CONV_WR, POOL_RD, POOL_WR, DONE} state_t;
  localparam int NTAPS = 9;
  localparam int DEF_TAP [NTAPS] = '{4, -1, 4, -2, 8, -2, -1, -1, -1};
  localparam int DEF_BIAS = -10;
  localparam int TAP_DR [NTAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [NTAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
endpackage

// File: rtl/conv_pool_engine_if.sv
// conv_pool_engine_if: image read port plus layer0/layer1 scratch memory port
interface conv_pool_engine_if #(parameter int AW = 6, parameter int DW = 13);
  logic [2*AW-1:0] iaddr, caddr_wr, caddr_rd;
  logic signed [DW-1:0] idata, cdata_wr, cdata_rd;
  logic cwr, crd, csel;
  modport master(output iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, input idata, cdata_rd);
  modport slave(input iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, output idata, cdata_rd);
endinterface

// File: rtl/conv_pool_dp.sv
// conv_pool_dp: MAC accumulator with saturate/ReLU, and 2x2 max/average pooling with round-up
module conv_pool_dp #(parameter int DW = 13, parameter int FRAC = 4) (
  input  logic clk,
  input  logic reset,
  input  logic conv_preset,
  input  logic conv_acc,
  input  logic relu,
  input  logic pool_first,
  input  logic pool_acc,
  input  logic pool_avg,
  input  logic signed [DW-1:0] pix,
  input  logic signed [DW-1:0] wt,
  input  logic signed [DW-1:0] bias,
  input  logic signed [DW-1:0] pool_pix,
  output logic signed [DW-1:0] conv_res,
  output logic signed [DW-1:0] pool_res
);
  localparam int ACCW = 2*DW + 4;
  localparam int PW = DW + 2;
  localparam logic signed [ACCW-1:0] SMAX = ACCW'((1 << (DW-1)) - 1);
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;
  localparam logic signed [PW-1:0] PMAX = PW'((1 << (DW-1)) - 1);
  localparam logic signed [PW-1:0] ONE = PW'(1 << FRAC);
  localparam logic signed [PW-1:0] FMASK = PW'((1 << FRAC) - 1);
  logic signed [ACCW-1:0] acc_q, acc_d, sh;
  logic signed [PW-1:0] pool_q, pool_d, pix_e, pv, pr;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0] sat;
  always_comb begin
    prod = pix * wt;
    acc_d = conv_preset ? ACCW'(bias) <<< FRAC : conv_acc ? acc_q + ACCW'(prod) : acc_q;
    sh = acc_q >>> FRAC;
    sat = sh > SMAX ? SMAX[DW-1:0] : sh < SMIN ? SMIN[DW-1:0] : sh[DW-1:0];
    conv_res = relu && sat[DW-1] ? '0 : sat;
    pix_e = PW'(pool_pix);
    pool_d = pool_first ? pix_e : !pool_acc ? pool_q : pool_avg ? pool_q + pix_e : pix_e > pool_q ? pix_e : pool_q;
    pv = pool_avg ? pool_q >>> 2 : pool_q;
    // any fractional residue bumps the value to the next integer, clipped at the positive limit
    pr = |pv[FRAC-1:0] ? (pv & ~FMASK) + ONE : pv;
    pool_res = pr > PMAX ? PMAX[DW-1:0] : pr[DW-1:0];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_q <= '0;
      pool_q <= '0;
    end else begin
      acc_q <= acc_d;
      pool_q <= pool_d;
    end
endmodule

// File: rtl/conv_pool_engine.sv
// conv_pool_engine: 3x3 conv (replicate padding, optional atrous step) into layer0,
// then 2x2 max/avg pooling of layer0 into layer1
module conv_pool_engine
  import conv_pkg::*;
#(parameter int AW = 6, parameter int DW = 13, parameter int FRAC = 4) (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic busy,
  input  logic dilation,
  input  logic pool_avg,
  input  logic relu_en,
  input  logic kw_en,
  input  logic [3:0] kw_idx,
  input  logic signed [DW-1:0] kw_data,
  conv_pool_engine_if.master bus
);
  localparam int N = 1 << AW;
  localparam logic [2*AW-1:0] LAST_C = '1;
  localparam logic [2*AW-1:0] LAST_P = (2*AW)'(N*N/4 - 1);
  localparam logic [2*AW-1:0] ONE_C = (2*AW)'(1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, k, wk;
  logic [2*AW-1:0] ctr_q, ctr_d;
  logic busy_q, busy_d, dil_q, dil_d, avg_q, avg_d, relu_q, relu_d;
  logic signed [DW-1:0] w_q [NTAPS];
  logic signed [DW-1:0] w_d [NTAPS];
  logic signed [DW-1:0] bias_q, bias_d, wt, conv_res, pool_res;
  logic [AW-1:0] row, col;
  int s;
  function automatic logic [AW-1:0] clampc(input logic [AW-1:0] c, input int d);
    int v;
    v = int'(c) + d;
    return v < 0 ? '0 : v >= N ? AW'(N - 1) : AW'(v);
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ctr_d = ctr_q;
    busy_d = busy_q;
    dil_d = dil_q;
    avg_d = avg_q;
    relu_d = relu_q;
    w_d = w_q;
    bias_d = bias_q;
    case (state_q)
      IDLE: begin
        if (kw_en && kw_idx < 4'd9) w_d[kw_idx] = kw_data;
        if (kw_en && kw_idx == 4'd9) bias_d = kw_data;
        if (ready) begin
          state_d = CONV_RD;
          busy_d = 1'b1;
          cnt_d = '0;
          ctr_d = '0;
          dil_d = dilation;
          avg_d = pool_avg;
          relu_d = relu_en;
        end
      end
      CONV_RD: begin
        cnt_d = cnt_q == 4'd9 ? 4'd0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'd9 ? CONV_WR : CONV_RD;
      end
      CONV_WR: begin
        ctr_d = ctr_q + ONE_C;
        state_d = ctr_q == LAST_C ? POOL_RD : CONV_RD;
      end
      POOL_RD: begin
        cnt_d = cnt_q == 4'd4 ? 4'd0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'd4 ? POOL_WR : POOL_RD;
      end
      POOL_WR: begin
        ctr_d = ctr_q == LAST_P ? '0 : ctr_q + ONE_C;
        state_d = ctr_q == LAST_P ? DONE : POOL_RD;
      end
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // tap k is addressed in cycle k and its pixel is multiplied by w[k] one cycle later
  always_comb begin
    k = cnt_q < 4'd9 ? cnt_q : 4'd0;
    wk = cnt_q - 4'd1;
    s = dil_q ? 2 : 1;
    row = clampc(ctr_q[2*AW-1:AW], TAP_DR[k] * s);
    col = clampc(ctr_q[AW-1:0], TAP_DC[k] * s);
    wt = cnt_q == 4'd0 ? '0 : w_q[wk];
  end
  assign busy = busy_q;
  assign bus.iaddr = state_q == CONV_RD && cnt_q < 4'd9 ? {row, col} : '0;
  assign bus.crd = state_q == POOL_RD && cnt_q < 4'd4;
  assign bus.caddr_rd = bus.crd ? {ctr_q[2*AW-3:AW-1], cnt_q[1], ctr_q[AW-2:0], cnt_q[0]} : '0;
  assign bus.cwr = state_q == CONV_WR || state_q == POOL_WR;
  assign bus.csel = state_q == POOL_WR;
  assign bus.caddr_wr = state_q == CONV_WR ? ctr_q : state_q == POOL_WR ? {2'b00, ctr_q[2*AW-3:0]} : '0;
  assign bus.cdata_wr = state_q == CONV_WR ? conv_res : state_q == POOL_WR ? pool_res : '0;
  conv_pool_dp #(.DW(DW), .FRAC(FRAC)) u_dp (
    .clk(clk),
    .reset(reset),
    .conv_preset(state_q == CONV_RD && cnt_q == 4'd0),
    .conv_acc(state_q == CONV_RD && cnt_q != 4'd0),
    .relu(relu_q),
    .pool_first(state_q == POOL_RD && cnt_q == 4'd1),
    .pool_acc(state_q == POOL_RD && cnt_q > 4'd1),
    .pool_avg(avg_q),
    .pix(bus.idata),
    .wt(wt),
    .bias(bias_q),
    .pool_pix(bus.cdata_rd),
    .conv_res(conv_res),
    .pool_res(pool_res)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ctr_q <= '0;
      busy_q <= 1'b0;
      dil_q <= 1'b0;
      avg_q <= 1'b0;
      relu_q <= 1'b0;
      bias_q <= DW'(DEF_BIAS);
      for (int i = 0; i < NTAPS; i++) w_q[i] <= DW'(DEF_TAP[i]);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ctr_q <= ctr_d;
      busy_q <= busy_d;
      dil_q <= dil_d;
      avg_q <= avg_d;
      relu_q <= relu_d;
      bias_q <= bias_d;
      w_q <= w_d;
    end
endmodule
